// File: rtl/ahb_arb_pkg.sv
// Shared types and constants for the AHB round-robin arbiter.
// Split support is compiled in with the AHB_ARB_SPLIT_EN macro.
package ahb_arb_pkg;
  localparam int MAX_MASTERS = 16;

  typedef enum logic [1:0] {
    PARK   = 2'd0,
    GRANT  = 2'd1,
    LOCKED = 2'd2
  } arb_state_t;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;
  localparam logic [1:0] HRESP_RETRY = 2'b10;
  localparam logic [1:0] HRESP_SPLIT = 2'b11;
endpackage

// File: rtl/ahb_rr_pick.sv
// Rotating-priority search: first set request bit above ptr, wrapping around.
module ahb_rr_pick
  import ahb_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          vld,
  output logic [IW-1:0] idx
);
  logic [IW-1:0] j;

  // Walk offsets from farthest to nearest so the nearest hit is written last.
  always_comb begin
    vld = 1'b0;
    idx = '0;
    j   = '0;
    for (int k = N; k >= 1; k--) begin
      j = IW'((int'(ptr) + k) % N);
      if (req[j]) begin
        vld = 1'b1;
        idx = j;
      end
    end
  end
endmodule

// File: rtl/ahb_rr_arbiter.sv
// AHB round-robin bus arbiter with locked-transfer hold and default-master parking.
// Define AHB_ARB_SPLIT_EN to compile in SPLIT masking of masters.
module ahb_rr_arbiter
  import ahb_arb_pkg::*;
#(
  parameter int NUM_MASTERS    = 4,
  parameter int DEFAULT_MASTER = 0
) (
  input  logic                           HCLK,
  input  logic                           HRESET,
  input  logic [NUM_MASTERS-1:0]         HBUSREQx,
  input  logic [NUM_MASTERS-1:0]         HLOCKx,
  input  logic [NUM_MASTERS-1:0]         HSPLIT,
  input  logic [1:0]                     HRESP,
  input  logic                           HREADY,
  output logic [NUM_MASTERS-1:0]         HGRANTx,
  output logic [$clog2(NUM_MASTERS)-1:0] HMASTER,
  output logic                           HMASTLOCK
);
  localparam int IW = $clog2(NUM_MASTERS);
  localparam logic [IW-1:0] DEF = IW'(DEFAULT_MASTER);
  localparam logic [NUM_MASTERS-1:0] ONE = {{(NUM_MASTERS-1){1'b0}}, 1'b1};

  arb_state_t             state;
  logic [IW-1:0]          owner, rr_ptr, pick_idx;
  logic [NUM_MASTERS-1:0] split_mask, eligible;
  logic                   pick_vld;

  assign eligible = HBUSREQx & ~split_mask;

  ahb_rr_pick #(.N(NUM_MASTERS), .IW(IW)) u_pick (
    .req (eligible),
    .ptr (rr_ptr),
    .vld (pick_vld),
    .idx (pick_idx)
  );

`ifdef AHB_ARB_SPLIT_EN
  // Set is applied after clear so a same-edge collision leaves the bit set.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      split_mask <= '0;
    end else begin
      split_mask <= split_mask & ~HSPLIT;
      if (HRESP == HRESP_SPLIT && !HREADY) split_mask[HMASTER] <= 1'b1;
    end
  end
`else
  logic unused_split;
  assign unused_split = ^{HSPLIT, HRESP};
  assign split_mask   = '0;
`endif

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state     <= PARK;
      owner     <= DEF;
      rr_ptr    <= DEF;
      HGRANTx   <= ONE << DEFAULT_MASTER;
      HMASTER   <= DEF;
      HMASTLOCK <= 1'b0;
    end else if (HREADY) begin
      HMASTER   <= owner;
      HMASTLOCK <= (state == LOCKED);
      if (state == LOCKED && HLOCKx[owner] && !split_mask[owner]) begin
        state <= LOCKED;
      end else if (eligible[owner] && HLOCKx[owner]) begin
        state <= LOCKED;
      end else if (pick_vld) begin
        state   <= GRANT;
        owner   <= pick_idx;
        rr_ptr  <= pick_idx;
        HGRANTx <= ONE << pick_idx;
      end else begin
        // Park keeps the pointer so rotation resumes where it left off.
        state   <= PARK;
        owner   <= DEF;
        HGRANTx <= ONE << DEFAULT_MASTER;
      end
    end
  end
endmodule

// File: tb/tb_ahb_rr_arbiter.sv
// Self-checking bench for ahb_rr_arbiter: directed scenarios plus a random run
// against a behavioural model. Split scenario runs when AHB_ARB_SPLIT_EN is set.
module tb_ahb_rr_arbiter;
  localparam int N   = 4;
  localparam int DEF = 0;
`ifdef AHB_ARB_SPLIT_EN
  localparam bit SPLIT_EN = 1'b1;
`else
  localparam bit SPLIT_EN = 1'b0;
`endif

  logic         HCLK = 1'b0;
  logic         HRESET;
  logic [N-1:0] HBUSREQx, HLOCKx, HSPLIT, HGRANTx;
  logic [1:0]   HRESP;
  logic         HREADY;
  logic [1:0]   HMASTER;
  logic         HMASTLOCK;

  int checks = 0;
  int failures = 0;

  // Behavioural model state
  int     m_owner, m_ptr, m_hmaster;
  bit     m_locked, m_hmastlock;
  bit [N-1:0] m_mask;

  ahb_rr_arbiter #(.NUM_MASTERS(N), .DEFAULT_MASTER(DEF)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .HBUSREQx(HBUSREQx), .HLOCKx(HLOCKx),
    .HSPLIT(HSPLIT), .HRESP(HRESP), .HREADY(HREADY), .HGRANTx(HGRANTx),
    .HMASTER(HMASTER), .HMASTLOCK(HMASTLOCK)
  );

  always #5 HCLK = ~HCLK;

  a_onehot: assert property (@(posedge HCLK) disable iff (HRESET) $onehot(HGRANTx));

  task automatic model_edge();
    bit [N-1:0] msk_old;
    bit found;
    int j;
    msk_old = m_mask;
    if (SPLIT_EN) begin
      for (int i = 0; i < N; i++) if (HSPLIT[i]) m_mask[i] = 1'b0;
      if (HRESP == 2'b11 && !HREADY) m_mask[m_hmaster] = 1'b1;
    end
    if (HREADY) begin
      m_hmaster   = m_owner;
      m_hmastlock = m_locked;
      if (m_locked && HLOCKx[m_owner] && !msk_old[m_owner]) begin
        m_locked = 1'b1;
      end else if (HBUSREQx[m_owner] && HLOCKx[m_owner] && !msk_old[m_owner]) begin
        m_locked = 1'b1;
      end else begin
        found = 1'b0;
        m_locked = 1'b0;
        for (int k = 1; k <= N; k++) begin
          j = (m_ptr + k) % N;
          if (!found && HBUSREQx[j] && !msk_old[j]) begin
            found = 1'b1; m_owner = j; m_ptr = j;
          end
        end
        if (!found) m_owner = DEF;
      end
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge HCLK);
    #1;
  endtask

  task automatic do_reset();
    HRESET = 1'b1; HBUSREQx = '0; HLOCKx = '0; HSPLIT = '0; HRESP = 2'b00; HREADY = 1'b1;
    @(posedge HCLK);
    #1;
    m_owner = DEF; m_ptr = DEF; m_hmaster = DEF; m_locked = 0; m_hmastlock = 0; m_mask = '0;
    HRESET = 1'b0;
  endtask

  task automatic test_reset();
    HRESET = 1'b1; HBUSREQx = '0; HLOCKx = '0; HSPLIT = '0; HRESP = 2'b00; HREADY = 1'b1;
    #2;
    checks++;
    if (HGRANTx !== 4'b0001 || HMASTER !== 2'd0 || HMASTLOCK !== 1'b0) begin
      failures++;
      $display("FAIL reset_vals: grant=%b master=%0d lock=%b required 0001/0/0", HGRANTx, HMASTER, HMASTLOCK);
    end
    do_reset();
    tick();
    checks++;
    if (HGRANTx !== 4'b0001 || HMASTER !== 2'd0) begin
      failures++;
      $display("FAIL park_idle: grant=%b master=%0d required 0001/0", HGRANTx, HMASTER);
    end
  endtask

  task automatic test_rotate();
    int exp_g[5] = '{1, 2, 3, 0, 1};
    int prev = 0;
    do_reset();
    HBUSREQx = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (HGRANTx !== 4'(1 << exp_g[i]) || HMASTER !== 2'(prev)) begin
        failures++;
        $display("FAIL rotate[%0d]: grant=%b master=%0d required grant idx %0d master %0d",
                 i, HGRANTx, HMASTER, exp_g[i], prev);
      end
      prev = exp_g[i];
    end
  endtask

  task automatic test_lock();
    do_reset();
    HBUSREQx = 4'b0100;
    tick();
    checks++;
    if (HGRANTx !== 4'b0100) begin
      failures++; $display("FAIL lock_setup: grant=%b required 0100", HGRANTx);
    end
    HBUSREQx = 4'b1110; HLOCKx = 4'b0100;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (HGRANTx !== 4'b0100 || (i >= 1 && HMASTLOCK !== 1'b1)) begin
        failures++;
        $display("FAIL lock_hold[%0d]: grant=%b mastlock=%b required 0100/1", i, HGRANTx, HMASTLOCK);
      end
    end
    HLOCKx = 4'b0000;
    tick();
    checks++;
    if (HGRANTx !== 4'b1000) begin
      failures++; $display("FAIL lock_release: grant=%b required 1000", HGRANTx);
    end
    tick();
    checks++;
    if (HMASTLOCK !== 1'b0 || HMASTER !== 2'd3) begin
      failures++; $display("FAIL lock_clear: mastlock=%b master=%0d required 0/3", HMASTLOCK, HMASTER);
    end
  endtask

  task automatic test_wait();
    do_reset();
    HBUSREQx = 4'b0010;
    tick();
    HREADY = 1'b0; HBUSREQx = 4'b1000;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (HGRANTx !== 4'b0010 || HMASTER !== 2'd0) begin
        failures++;
        $display("FAIL wait_hold[%0d]: grant=%b master=%0d required 0010/0", i, HGRANTx, HMASTER);
      end
    end
    HREADY = 1'b1;
    tick();
    checks++;
    if (HGRANTx !== 4'b1000 || HMASTER !== 2'd1) begin
      failures++; $display("FAIL wait_resume: grant=%b master=%0d required 1000/1", HGRANTx, HMASTER);
    end
  endtask

  task automatic test_split();
    do_reset();
    HBUSREQx = 4'b0010;
    tick();
    tick();
    HREADY = 1'b0; HRESP = 2'b11;
    tick();
    HREADY = 1'b1;
    tick();
    checks++;
    if (HGRANTx !== 4'b0001) begin
      failures++; $display("FAIL split_park: grant=%b required 0001", HGRANTx);
    end
    HRESP = 2'b00;
    tick();
    HSPLIT = 4'b0010;
    tick();
    checks++;
    if (HGRANTx !== 4'b0001) begin
      failures++; $display("FAIL split_masked: grant=%b required 0001", HGRANTx);
    end
    HSPLIT = 4'b0000;
    tick();
    checks++;
    if (HGRANTx !== 4'b0010) begin
      failures++; $display("FAIL split_resume: grant=%b required 0010", HGRANTx);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    HBUSREQx = 4'b0100;
    tick();
    HLOCKx = 4'b0100;
    tick();
    tick();
    HREADY = 1'b0;
    #2;
    HRESET = 1'b1;
    #1;
    checks++;
    if (HGRANTx !== 4'b0001 || HMASTER !== 2'd0 || HMASTLOCK !== 1'b0) begin
      failures++;
      $display("FAIL async_reset: grant=%b master=%0d lock=%b required 0001/0/0", HGRANTx, HMASTER, HMASTLOCK);
    end
    do_reset();
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 500; c++) begin
      HBUSREQx = 4'($urandom);
      HLOCKx   = 4'($urandom & $urandom);
      HREADY   = ($urandom_range(0, 3) != 0);
      HSPLIT   = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'b0000;
      HRESP    = ($urandom_range(0, 2) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      tick();
      checks++;
      if (HGRANTx !== 4'(1 << m_owner) || HMASTER !== 2'(m_hmaster) ||
          HMASTLOCK !== m_hmastlock || !$onehot(HGRANTx)) begin
        failures++;
        $display("FAIL random[%0d]: grant=%b master=%0d lock=%b required grant idx %0d master %0d lock %b",
                 c, HGRANTx, HMASTER, HMASTLOCK, m_owner, m_hmaster, m_hmastlock);
      end
    end
  endtask

  initial begin
    test_reset();
    test_rotate();
    test_lock();
    test_wait();
    if (SPLIT_EN) test_split();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
